// File: rtl/dvs_pkg.sv
// Shared definitions for the event-camera packet decoder.
package dvs_pkg;

    localparam int         PKT_LEN       = 7;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_STALL   = 2'd3
    } state_t;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic        pol;
        logic [15:0] ts;
    } evt_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/event_out_reg.sv
// One-entry output holding register with valid/ready handshake; 1-cycle load latency.
// in_rdy = !out_vld || out_rdy, so a held entry is only replaced on the cycle it is consumed.
module event_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (in_vld) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign in_rdy  = !vld_q || out_rdy;
    assign out_vld = vld_q;
    assign out_dat = dat_q;

endmodule

// File: rtl/event_stream_driver.sv
// Decodes 7-byte sync/checksum packets from a UART byte stream into DVS events; 1 cycle from last byte to event_valid.
// Stalls the byte stream (byte_ready low) on the checksum byte while an unconsumed event is held.
module event_stream_driver
    import dvs_pkg::*;
#(
    parameter int         SENSOR_RES     = 320,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        event_valid,
    output logic [8:0]  event_x,
    output logic [8:0]  event_y,
    output logic        event_polarity,
    output logic [15:0] event_ts,
    input  logic        event_ready,
    output logic [7:0]  pkt_ok_count,
    output logic [7:0]  pkt_err_count,
    output logic [1:0]  dbg_state
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]        RES_LIM   = 10'(SENSOR_RES);
    localparam logic [2:0]        LAST_IDX  = 3'(PKT_LEN - 2);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        cks_q, cks_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [4:0][7:0]   pl_q, pl_d;
    logic [7:0]        ok_q, ok_d, err_q, err_d;

    logic                    byte_acc;
    logic                    timeout;
    logic                    pkt_good;
    logic                    evt_in_rdy;
    logic                    evt_load_vld;
    evt_t                    cand;
    evt_t                    evt_out;
    logic [$bits(evt_t)-1:0] evt_out_dat;

    // Payload is a shift register: after B5, pl_q[4] holds B1 and pl_q[0] holds B5.
    assign cand = evt_t'({pl_q[2][0], pl_q[4], pl_q[2][1], pl_q[3], pl_q[2][2], pl_q[1], pl_q[0]});

    assign pkt_good = (byte_data == cks_q)
                   && (pl_q[2][7:3] == 5'd0)
                   && ({1'b0, cand.x} < RES_LIM)
                   && ({1'b0, cand.y} < RES_LIM);

    assign timeout = (idle_q == IDLE_LAST);

    always_comb begin
        byte_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_HUNT, ST_PAYLOAD: byte_ready = 1'b1;
                ST_CHECK:            byte_ready = evt_in_rdy;
                default:             byte_ready = 1'b0;
            endcase
        end
    end

    assign byte_acc = byte_valid && byte_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cks_d        = cks_q;
        idle_d       = idle_q;
        pl_d         = pl_q;
        ok_d         = ok_q;
        err_d        = err_q;
        evt_load_vld = 1'b0;
        case (state_q)
            ST_HUNT: begin
                idx_d  = 3'd0;
                cks_d  = 8'd0;
                idle_d = '0;
                if (byte_acc && byte_data == SYNC_BYTE) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = 3'd1;
                end
            end
            ST_PAYLOAD: begin
                if (byte_acc) begin
                    pl_d   = {pl_q[3:0], byte_data};
                    cks_d  = cks_q ^ byte_data;
                    idx_d  = idx_q + 3'd1;
                    idle_d = '0;
                    if (idx_q == LAST_IDX) state_d = ST_CHECK;
                end else if (timeout) begin
                    state_d = ST_HUNT;
                    err_d   = sat_inc8(err_q);
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (byte_acc) begin
                    state_d = ST_HUNT;
                    if (pkt_good) begin
                        evt_load_vld = 1'b1;
                        ok_d         = sat_inc8(ok_q);
                    end else begin
                        err_d = sat_inc8(err_q);
                    end
                end else if (byte_valid) begin
                    // Checksum byte is waiting behind an unconsumed event.
                    state_d = ST_STALL;
                end else if (timeout) begin
                    state_d = ST_HUNT;
                    err_d   = sat_inc8(err_q);
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_STALL: begin
                if (event_valid && event_ready) state_d = ST_CHECK;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            idx_q   <= 3'd0;
            cks_q   <= 8'd0;
            idle_q  <= '0;
            pl_q    <= '0;
            ok_q    <= 8'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cks_q   <= cks_d;
            idle_q  <= idle_d;
            pl_q    <= pl_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    event_out_reg #(
        .WIDTH($bits(evt_t))
    ) u_out (
        .clk    (clk),
        .rst    (rst),
        .in_vld (evt_load_vld),
        .in_dat (cand),
        .in_rdy (evt_in_rdy),
        .out_vld(event_valid),
        .out_dat(evt_out_dat),
        .out_rdy(event_ready)
    );

    assign evt_out        = evt_t'(evt_out_dat);
    assign event_x        = evt_out.x;
    assign event_y        = evt_out.y;
    assign event_polarity = evt_out.pol;
    assign event_ts       = evt_out.ts;
    assign pkt_ok_count   = ok_q;
    assign pkt_err_count  = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_event_stream_driver.sv
// Directed self-checking bench for event_stream_driver.
module tb_event_stream_driver;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        event_valid;
    logic [8:0]  event_x;
    logic [8:0]  event_y;
    logic        event_polarity;
    logic [15:0] event_ts;
    logic        event_ready;
    logic [7:0]  pkt_ok_count;
    logic [7:0]  pkt_err_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int stall_cyc = 0;
    int notrdy_cyc = 0;
    logic [34:0] ev_q[$];

    localparam logic [34:0] EV_P1 = {9'h03F, 9'h020, 1'b1, 16'h1234};
    localparam logic [34:0] EV_P2 = {9'h101, 9'h102, 1'b0, 16'hABCD};
    localparam logic [34:0] EV_P3 = {9'h000, 9'h13F, 1'b0, 16'h0001};

    event_stream_driver dut (
        .clk           (clk),
        .rst           (rst),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .event_valid   (event_valid),
        .event_x       (event_x),
        .event_y       (event_y),
        .event_polarity(event_polarity),
        .event_ts      (event_ts),
        .event_ready   (event_ready),
        .pkt_ok_count  (pkt_ok_count),
        .pkt_err_count (pkt_err_count),
        .dbg_state     (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst && event_valid && event_ready)
            ev_q.push_back({event_x, event_y, event_polarity, event_ts});
        if (dbg_state == 2'd3) stall_cyc++;
        if (dbg_state == 2'd2 && byte_valid && !byte_ready) notrdy_cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic [34:0] exp);
        chk({tag, "_vld"}, 64'(event_valid), 64'd1);
        chk({tag, "_dat"}, 64'({event_x, event_y, event_polarity, event_ts}), 64'(exp));
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk);
            #1;
            n++;
        end
        byte_valid = 1'b0;
        chk("byte_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] flip);
        send_byte(8'hA5);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
        send_byte(b5);
        send_byte(b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ flip);
    endtask

    initial begin
        int base;
        int st0;
        int nr0;
        rst         = 1'b1;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        event_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_event_valid", 64'(event_valid), 64'd0);
        chk("rst_event_dat", 64'({event_x, event_y, event_polarity, event_ts}), 64'd0);
        chk("rst_ok", 64'(pkt_ok_count), 64'd0);
        chk("rst_err", 64'(pkt_err_count), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;

        // Good packet, event valid exactly one cycle after B6 and for one cycle
        send_pkt(8'h3F, 8'h20, 8'h04, 8'h12, 8'h34, 8'h00);
        chk_evt("t1_evt", EV_P1);
        @(posedge clk);
        #1;
        chk("t1_one_cycle", 64'(event_valid), 64'd0);
        chk("t1_ok", 64'(pkt_ok_count), 64'd1);
        chk("t1_err", 64'(pkt_err_count), 64'd0);

        // Corrupted checksum, then a good packet
        send_pkt(8'h3F, 8'h20, 8'h04, 8'h12, 8'h34, 8'hFF);
        chk("t2_no_event", 64'(event_valid), 64'd0);
        chk("t2_err", 64'(pkt_err_count), 64'd1);
        send_pkt(8'h01, 8'h02, 8'h03, 8'hAB, 8'hCD, 8'h00);
        chk_evt("t2_evt", EV_P2);
        chk("t2_ok", 64'(pkt_ok_count), 64'd2);

        // x = 320 out of range, B3 reserved bit set, checksum+range together, y = 319 accepted
        send_pkt(8'h40, 8'h20, 8'h01, 8'h12, 8'h34, 8'h00);
        chk("t3_x_range_vld", 64'(event_valid), 64'd0);
        chk("t3_x_range_err", 64'(pkt_err_count), 64'd2);
        send_pkt(8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
        chk("t3_b3_err", 64'(pkt_err_count), 64'd3);
        send_pkt(8'h40, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
        chk("t3_double_err", 64'(pkt_err_count), 64'd4);
        chk("t3_ok_unchanged", 64'(pkt_ok_count), 64'd2);
        send_pkt(8'h00, 8'h3F, 8'h02, 8'h00, 8'h01, 8'h00);
        chk_evt("t3_y319_evt", EV_P3);
        chk("t3_ok", 64'(pkt_ok_count), 64'd3);
        @(posedge clk);
        #1;

        // Three back-to-back packets against a 50-cycle consumer stall
        base = ev_q.size();
        st0  = stall_cyc;
        nr0  = notrdy_cyc;
        event_ready = 1'b0;
        fork
            begin
                send_pkt(8'h3F, 8'h20, 8'h04, 8'h12, 8'h34, 8'h00);
                send_pkt(8'h01, 8'h02, 8'h03, 8'hAB, 8'hCD, 8'h00);
                send_pkt(8'h00, 8'h3F, 8'h02, 8'h00, 8'h01, 8'h00);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                chk_evt("t4_hold", EV_P1);
                chk("t4_stall_state", 64'(dbg_state), 64'd3);
                repeat (20) @(posedge clk);
                #1;
                event_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("t4_count", 64'(ev_q.size() - base), 64'd3);
        chk("t4_ev0", 64'(ev_q[base]), 64'(EV_P1));
        chk("t4_ev1", 64'(ev_q[base + 1]), 64'(EV_P2));
        chk("t4_ev2", 64'(ev_q[base + 2]), 64'(EV_P3));
        chk("t4_saw_stall", 64'(stall_cyc > st0), 64'd1);
        chk("t4_saw_notrdy", 64'(notrdy_cyc > nr0), 64'd1);
        chk("t4_ok", 64'(pkt_ok_count), 64'd6);
        chk("t4_err", 64'(pkt_err_count), 64'd4);

        // Inter-byte timeout: still in PAYLOAD after 1199 idle cycles, dropped at 1200
        send_byte(8'hA5);
        send_byte(8'h3F);
        repeat (1199) @(posedge clk);
        #1;
        chk("t5_pre_timeout_state", 64'(dbg_state), 64'd1);
        chk("t5_pre_timeout_err", 64'(pkt_err_count), 64'd4);
        @(posedge clk);
        #1;
        chk("t5_timeout_state", 64'(dbg_state), 64'd0);
        chk("t5_timeout_err", 64'(pkt_err_count), 64'd5);
        send_pkt(8'h3F, 8'h20, 8'h04, 8'h12, 8'h34, 8'h00);
        chk_evt("t5_evt", EV_P1);
        chk("t5_ok", 64'(pkt_ok_count), 64'd7);

        // Garbage in HUNT, then reset mid-packet with an event held
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        chk("t6_garbage_state", 64'(dbg_state), 64'd0);
        chk("t6_garbage_err", 64'(pkt_err_count), 64'd5);
        event_ready = 1'b0;
        send_pkt(8'h01, 8'h02, 8'h03, 8'hAB, 8'hCD, 8'h00);
        send_byte(8'hA5);
        send_byte(8'h3F);
        send_byte(8'h20);
        chk("t6_mid_state", 64'(dbg_state), 64'd1);
        chk("t6_mid_vld", 64'(event_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_vld", 64'(event_valid), 64'd0);
        chk("t6_rst_dat", 64'({event_x, event_y, event_polarity, event_ts}), 64'd0);
        chk("t6_rst_counts", 64'({pkt_ok_count, pkt_err_count}), 64'd0);
        chk("t6_rst_state", 64'(dbg_state), 64'd0);
        chk("t6_rst_byte_ready", 64'(byte_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        event_ready = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(8'h01, 8'h02, 8'h03, 8'hAB, 8'hCD, 8'h00);
        chk_evt("t6_evt", EV_P2);
        chk("t6_ok", 64'(pkt_ok_count), 64'd1);
        chk("t6_err", 64'(pkt_err_count), 64'd0);

        // Counter saturation
        for (int i = 0; i < 260; i++) send_pkt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        chk("t7_err_sat", 64'(pkt_err_count), 64'd255);
        for (int i = 0; i < 256; i++) send_pkt(8'h3F, 8'h20, 8'h04, 8'h12, 8'h34, 8'h00);
        chk("t7_ok_sat", 64'(pkt_ok_count), 64'd255);
        chk("t7_err_hold", 64'(pkt_err_count), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_stream_driver.md
EVENT_STREAM_DRIVER -- requirements
Module: event_stream_driver

Interface
REQ-001 SHALL have parameter SENSOR_RES, default 320: exclusive upper bound for the x and y coordinates.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: the packet header byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1200: maximum idle gap allowed between bytes inside one packet (100 us at 12 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports byte_valid (input, 1), byte_data (input, 8) and byte_ready (output, 1): the byte stream from the UART receiver.
REQ-007 SHALL have ports event_valid (output, 1), event_x (output, 9), event_y (output, 9), event_polarity (output, 1), event_ts (output, 16) and event_ready (input, 1): the event producer side of the accelerator's event interface.
REQ-008 SHALL have ports pkt_ok_count (output, 8) and pkt_err_count (output, 8): saturating status counters.
REQ-009 SHALL have port dbg_state (output, 2): the current FSM state encoding.

Function
REQ-010 A byte transfer SHALL occur when byte_valid && byte_ready; an event transfer SHALL occur when event_valid && event_ready.
REQ-011 The packet SHALL be 7 bytes, in order:
- B0 = SYNC_BYTE
- B1 = x[7:0]
- B2 = y[7:0]
- B3 = {5'b0, pol, y[8], x[8]}
- B4 = ts[15:8]
- B5 = ts[7:0]
- B6 = B1^B2^B3^B4^B5
REQ-012 The FSM SHALL have the states HUNT=0, PAYLOAD=1, CHECK=2 and STALL=3.
REQ-013 In HUNT, a byte equal to SYNC_BYTE SHALL move the FSM to PAYLOAD with the byte index set to 1; any other byte SHALL be discarded silently with no error count.
REQ-014 In PAYLOAD, each accepted byte SHALL be stored and XORed into the running checksum; after B5 is accepted, the FSM SHALL move to CHECK.
REQ-015 In CHECK, the accepted B6 SHALL be validated. A packet is valid only if all of the following hold:
- B6 equals the running checksum
- B3[7:3] == 0
- x < SENSOR_RES
- y < SENSOR_RES
REQ-016 For a valid packet, the output register SHALL load on the cycle after B6 is accepted, event_valid SHALL assert, pkt_ok_count SHALL increment, and the FSM SHALL return to HUNT.
REQ-017 For an invalid packet, the packet SHALL be dropped, pkt_err_count SHALL increment, and the FSM SHALL return to HUNT.
REQ-018 Latency from B6 accepted to event_valid high SHALL be exactly 1 cycle.
REQ-019 byte_ready SHALL be high in HUNT and PAYLOAD. In CHECK it SHALL be high only when !event_valid || event_ready, so a completed event never overwrites an unconsumed one.
REQ-020 If the FSM is in CHECK with byte_valid high but byte_ready low, it SHALL enter STALL. In STALL, byte_ready SHALL be 0 and the timeout counter SHALL be frozen. It SHALL return to CHECK on the cycle after the event transfer.
REQ-021 event_valid SHALL stay high, and event_x/y/polarity/ts SHALL stay stable, until the event transfer occurs.
REQ-022 If a new event loads on the same cycle as a transfer, event_valid SHALL remain high with the new data (back-to-back throughput).
REQ-023 In PAYLOAD and CHECK, the idle counter SHALL reset on each accepted byte. When it reaches TIMEOUT_CYCLES, the partial packet SHALL be dropped, pkt_err_count SHALL increment, and the FSM SHALL go to HUNT.
REQ-024 A SYNC_BYTE value arriving in PAYLOAD SHALL be treated as data, not as a resynchronisation.
REQ-025 If a checksum error and a range error occur together, pkt_err_count SHALL increment once.
REQ-026 pkt_ok_count and pkt_err_count SHALL each saturate at 255 and never wrap.

Reset
REQ-027 While rst is high, the following SHALL hold:
- FSM = HUNT
- byte index, checksum and idle counter = 0
- event_valid = 0; event_x, event_y, event_ts, event_polarity = 0
- both counters = 0
- byte_ready = 1 only after rst deasserts
REQ-028 Reset asserted mid-packet or with event_valid high SHALL discard all partial and pending data; there is no recovery of an in-flight event.

Structure
REQ-029 The FSM state enum, the packet length constant (7) and SYNC_BYTE's default SHALL live in a shared package, dvs_pkg.
REQ-030 The output holding register and valid/ready logic SHALL be one sub-module, event_out_reg, parameterised by data width.
REQ-031 The RTL SHALL contain no inferred memories; payload storage SHALL be 5 flops of 8 bits.

Verification
REQ-032 Packet A5 40 20 05 12 34 (checksum computed), with event_ready=1 -> one event with x=320? No: x=0x140 flags range error; instead send A5 3F 20 04 12 34 cks -> x=63, y=32, pol=1, ts=0x1234, event_valid for 1 cycle, pkt_ok_count=1.
REQ-033 Same packet with corrupted B6 -> no event_valid, pkt_err_count=1, and a following good packet is decoded correctly.
REQ-034 Packet with x=0x140 (B3=01, B1=40) and a correct checksum -> dropped, pkt_err_count=1.
REQ-035 Three back-to-back good packets with event_ready held 0 for 50 cycles -> byte_ready low in CHECK, STALL entered, no loss, and three events delivered in order after release.
REQ-036 Sending A5 3F followed by a 1200-cycle gap, then a full good packet -> pkt_err_count=1, pkt_ok_count=1.
REQ-037 Garbage bytes 00 FF 13 before a good packet, plus rst pulsed mid-packet -> no error counts for the garbage, all outputs 0 after rst, and the next good packet decoded.
